// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg
//   Shared constants and types for the MINI-RISC fetch stage: default widths,
//   the NOP encoding, instruction field positions and the in-flight word FSM
//   state encoding.
package fetch_stage_pkg;

   localparam int ADDR_W_DEF  = 8;
   localparam int INSTR_W_DEF = 16;

   // All-zero word is the NOP, so bubble fields decode to zero.
   localparam logic [15:0] NOP_INSTR = 16'h0000;

   // Field positions within an instruction word.
   localparam int OPC_LSB = 11;
   localparam int OPC_W   = 5;
   localparam int RD_LSB  = 8;
   localparam int RS1_LSB = 5;
   localparam int RS2_LSB = 2;
   localparam int REG_W   = 3;

   // Where the word returning from imem (or held back) currently lives.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,   // returning word is stale, ignore it
      ST_RUN   = 2'd1,   // imem_rdata is valid for the tagged PC
      ST_HOLD  = 2'd2    // skid register owns the next instruction
   } fetch_state_e;

endpackage

// File: rtl/fetch_stage_fd_pipe_reg.sv
// fd_pipe_reg
//   Fetch/Decode pipeline register. Priority: rst > flush > stall > load.
//   A flush or a load with ld_valid=0 inserts a bubble (NOP, valid=0) and
//   keeps the previous PC.
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush, stall        hazard controls
//   ld_valid/instr/pc   candidate entry for this cycle
//   fd_instr_q/pc_q/valid_q  registered Decode-stage entry
module fd_pipe_reg
   import fetch_stage_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               stall,
   input  logic               ld_valid,
   input  logic [INSTR_W-1:0] ld_instr,
   input  logic [ADDR_W-1:0]  ld_pc,
   output logic [INSTR_W-1:0] fd_instr_q,
   output logic [ADDR_W-1:0]  fd_pc_q,
   output logic               fd_valid_q
);

   logic [INSTR_W-1:0] fd_instr_d;
   logic [ADDR_W-1:0]  fd_pc_d;
   logic               fd_valid_d;

   always_comb begin
      fd_instr_d = fd_instr_q;
      fd_pc_d    = fd_pc_q;
      fd_valid_d = fd_valid_q;
      if (flush) begin
         fd_instr_d = INSTR_W'(NOP_INSTR);
         fd_valid_d = 1'b0;
      end else if (!stall) begin
         if (ld_valid) begin
            fd_instr_d = ld_instr;
            fd_pc_d    = ld_pc;
            fd_valid_d = 1'b1;
         end else begin
            fd_instr_d = INSTR_W'(NOP_INSTR);
            fd_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fd_instr_q <= INSTR_W'(NOP_INSTR);
         fd_pc_q    <= '0;
         fd_valid_q <= 1'b0;
      end else begin
         fd_instr_q <= fd_instr_d;
         fd_pc_q    <= fd_pc_d;
         fd_valid_q <= fd_valid_d;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//   MINI-RISC fetch: PC register, synchronous 1-cycle imem interface, a
//   one-entry skid register for the in-flight word, and the FD register.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   stall_F, flush_F         hazard unit controls
//   redirect_valid/pc        taken branch/jump target
//   imem_addr / imem_rdata   instruction memory (data returns one cycle later)
//   instr_D, pc_D, valid_D   Decode-stage instruction, its PC, bubble flag
//   opcode_D, rd_D, source_reg1_D, source_reg2_D  fields of instr_D
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int               ADDR_W   = ADDR_W_DEF,
   parameter int               INSTR_W  = INSTR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall_F,
   input  logic               flush_F,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr_D,
   output logic [ADDR_W-1:0]  pc_D,
   output logic               valid_D,
   output logic [OPC_W-1:0]   opcode_D,
   output logic [REG_W-1:0]   rd_D,
   output logic [REG_W-1:0]   source_reg1_D,
   output logic [REG_W-1:0]   source_reg2_D
);

   fetch_state_e       state_q, state_d;
   logic [ADDR_W-1:0]  pc_f_q, pc_f_d;
   // PC presented last cycle; tags the word now on imem_rdata.
   logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
   logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
   logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;

   logic               ld_valid;
   logic [INSTR_W-1:0] ld_instr;
   logic [ADDR_W-1:0]  ld_pc;
   logic               skid_capture;

   assign imem_addr = pc_f_q;

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_EMPTY;
      else     state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: state_d = ST_RUN;
         ST_RUN:   state_d = stall_F ? ST_HOLD : ST_RUN;
         ST_HOLD:  state_d = stall_F ? ST_HOLD : ST_RUN;
         default:  state_d = ST_EMPTY;
      endcase
      // A redirect makes the word returning next cycle stale.
      if (redirect_valid) state_d = ST_EMPTY;
   end

   // FSM: outputs (what the FD register may load, whether to park the word)
   always_comb begin
      ld_valid     = 1'b0;
      ld_instr     = imem_rdata;
      ld_pc        = inflight_pc_q;
      skid_capture = 1'b0;
      case (state_q)
         ST_RUN: begin
            ld_valid     = 1'b1;
            skid_capture = stall_F;
         end
         ST_HOLD: begin
            ld_valid = 1'b1;
            ld_instr = skid_instr_q;
            ld_pc    = skid_pc_q;
         end
         default: ;
      endcase
   end

   // PC, tag and skid datapath
   always_comb begin
      inflight_pc_d = pc_f_q;
      skid_instr_d  = skid_instr_q;
      skid_pc_d     = skid_pc_q;
      if (redirect_valid)   pc_f_d = redirect_pc;
      else if (stall_F)     pc_f_d = pc_f_q;
      else                  pc_f_d = pc_f_q + ADDR_W'(1);
      if (redirect_valid) begin
         skid_instr_d = '0;
         skid_pc_d    = '0;
      end else if (skid_capture) begin
         skid_instr_d = imem_rdata;
         skid_pc_d    = inflight_pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_f_q        <= RESET_PC;
         inflight_pc_q <= '0;
         skid_instr_q  <= '0;
         skid_pc_q     <= '0;
      end else begin
         pc_f_q        <= pc_f_d;
         inflight_pc_q <= inflight_pc_d;
         skid_instr_q  <= skid_instr_d;
         skid_pc_q     <= skid_pc_d;
      end
   end

   // flush wins over stall here, while the FSM above still sees the stall.
   fd_pipe_reg #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
   ) u_fd (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush_F),
      .stall      (stall_F),
      .ld_valid   (ld_valid),
      .ld_instr   (ld_instr),
      .ld_pc      (ld_pc),
      .fd_instr_q (instr_D),
      .fd_pc_q    (pc_D),
      .fd_valid_q (valid_D)
   );

   assign opcode_D      = instr_D[OPC_LSB +: OPC_W];
   assign rd_D          = instr_D[RD_LSB  +: REG_W];
   assign source_reg1_D = instr_D[RS1_LSB +: REG_W];
   assign source_reg2_D = instr_D[RS2_LSB +: REG_W];

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Bench for fetch_stage: directed scenarios plus randomized hazard traffic,
//   checked against a transaction-level model (fetch PC + one optional
//   in-flight PC + Decode slot).
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst, stall_F, flush_F, redirect_valid;
   logic [7:0]  redirect_pc;

   logic [7:0]  imem_addr, pc_D;
   logic [15:0] imem_rdata, instr_D;
   logic        valid_D;
   logic [4:0]  opcode_D;
   logic [2:0]  rd_D, source_reg1_D, source_reg2_D;

   logic [3:0]  imem_addr4, pc_D4;
   logic [15:0] imem_rdata4, instr_D4;
   logic        valid_D4;
   logic [4:0]  opcode_D4;
   logic [2:0]  rd_D4, rs1_D4, rs2_D4;

   logic [15:0] mem  [256];
   logic [15:0] mem4 [16];

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [7:0]  m_pc_f, m_inf_pc, m_pc_d;
   logic        m_inf_v, m_valid;
   logic [15:0] m_instr;

   always #5 clk = ~clk;
   always @(posedge clk) imem_rdata  <= mem[imem_addr];
   always @(posedge clk) imem_rdata4 <= mem4[imem_addr4];

   fetch_stage #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
      .clk(clk), .rst(rst), .stall_F(stall_F), .flush_F(flush_F),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .instr_D(instr_D), .pc_D(pc_D), .valid_D(valid_D),
      .opcode_D(opcode_D), .rd_D(rd_D),
      .source_reg1_D(source_reg1_D), .source_reg2_D(source_reg2_D)
   );

   fetch_stage #(.ADDR_W(4), .INSTR_W(16), .RESET_PC(4'h0)) dut4 (
      .clk(clk), .rst(rst), .stall_F(stall_F), .flush_F(flush_F),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc[3:0]),
      .imem_addr(imem_addr4), .imem_rdata(imem_rdata4),
      .instr_D(instr_D4), .pc_D(pc_D4), .valid_D(valid_D4),
      .opcode_D(opcode_D4), .rd_D(rd_D4),
      .source_reg1_D(rs1_D4), .source_reg2_D(rs2_D4)
   );

   logic [46:0] obs_vec;
   assign obs_vec = {instr_D, pc_D, valid_D, imem_addr,
                     opcode_D, rd_D, source_reg1_D, source_reg2_D};

   function automatic logic [46:0] exp_vec();
      return {m_instr, m_pc_d, m_valid, m_pc_f,
              m_instr[15:11], m_instr[10:8], m_instr[7:5], m_instr[4:2]};
   endfunction

   // Advance one clock; the model applies the same inputs at the same edge.
   task automatic step();
      logic [15:0] n_instr;
      logic [7:0]  n_pcd, n_pcf, n_infpc;
      logic        n_valid, n_infv;
      if (rst) begin
         n_instr = 16'h0; n_pcd = 8'h0; n_valid = 1'b0;
         n_infv = 1'b0; n_infpc = 8'h0; n_pcf = 8'h00;
      end else begin
         n_instr = m_instr; n_pcd = m_pc_d; n_valid = m_valid;
         if (flush_F) begin
            n_instr = 16'h0; n_valid = 1'b0;
         end else if (!stall_F) begin
            if (m_inf_v) begin
               n_instr = mem[m_inf_pc]; n_pcd = m_inf_pc; n_valid = 1'b1;
            end else begin
               n_instr = 16'h0; n_valid = 1'b0;
            end
         end
         n_infv = 1'b1; n_infpc = m_pc_f;
         if (redirect_valid) begin
            n_infv = 1'b0;
         end else if (m_inf_v && stall_F) begin
            n_infv = 1'b1; n_infpc = m_inf_pc;
         end
         if (redirect_valid) n_pcf = redirect_pc;
         else if (stall_F)   n_pcf = m_pc_f;
         else                n_pcf = m_pc_f + 8'd1;
      end
      @(posedge clk);
      m_instr = n_instr; m_pc_d = n_pcd; m_valid = n_valid;
      m_inf_v = n_infv;  m_inf_pc = n_infpc; m_pc_f = n_pcf;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; stall_F = 1'b0; flush_F = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 8'h00;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall_F = 1'b0; flush_F = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 8'h00;
      step(); step();
      checks++;
      if ({valid_D, instr_D, pc_D, imem_addr} !== {1'b0, 16'h0, 8'h0, 8'h00}) begin
         failures++;
         $display("FAIL reset got v=%b i=%h pc=%h a=%h want 0/0000/00/00",
                  valid_D, instr_D, pc_D, imem_addr);
      end
      rst = 1'b0;
   endtask

   task automatic test_stream();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step();
         checks++;
         if (obs_vec !== exp_vec()) begin
            failures++;
            $display("FAIL stream_model cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec());
         end
         if (i >= 1) begin
            checks++;
            if ({valid_D, instr_D, pc_D} !== {1'b1, 16'h1000 + 16'(i-1), 8'(i-1)}) begin
               failures++;
               $display("FAIL stream cyc=%0d got v=%b i=%h pc=%h want 1/%h/%h",
                        i, valid_D, instr_D, pc_D, 16'h1000 + 16'(i-1), 8'(i-1));
            end
         end
      end
   endtask

   task automatic test_stall();
      logic [15:0] want [7];
      logic [6:0]  stl;
      want = '{16'h1003, 16'h1003, 16'h1003, 16'h1004, 16'h1005, 16'h1005, 16'h1006};
      stl  = 7'b0100111;  // bit k = stall_F driven before step k
      do_reset();
      for (int n = 0; n < 12 && instr_D !== 16'h1003; n++) step();
      checks++;
      if (instr_D !== 16'h1003) begin
         failures++;
         $display("FAIL stall_reach got=%h want=1003", instr_D);
      end
      for (int k = 0; k < 7; k++) begin
         stall_F = stl[k];
         step();
         checks++;
         if (obs_vec !== exp_vec() || instr_D !== want[k] || valid_D !== 1'b1) begin
            failures++;
            $display("FAIL stall k=%0d got i=%h v=%b want i=%h v=1 (model %h vs %h)",
                     k, instr_D, valid_D, want[k], obs_vec, exp_vec());
         end
      end
      stall_F = 1'b0;
   endtask

   task automatic test_redirect();
      do_reset();
      for (int n = 0; n < 12 && !(valid_D === 1'b1 && pc_D === 8'h05); n++) step();
      checks++;
      if (pc_D !== 8'h05) begin
         failures++;
         $display("FAIL redir_reach got pc=%h want 05", pc_D);
      end
      redirect_valid = 1'b1; flush_F = 1'b1; redirect_pc = 8'h40;
      step();
      redirect_valid = 1'b0; flush_F = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) step();
         checks++;
         if (obs_vec !== exp_vec()
             || valid_D !== (k == 2)
             || (k == 2 && {instr_D, pc_D} !== {mem[8'h40], 8'h40})) begin
            failures++;
            $display("FAIL redirect k=%0d got v=%b i=%h pc=%h (exp vec %h)",
                     k, valid_D, instr_D, pc_D, exp_vec());
         end
      end
   endtask

   task automatic test_redirect_hold();
      bit seen;
      stall_F = 1'b1;
      step(); step();
      redirect_valid = 1'b1; redirect_pc = 8'h80;
      step();
      redirect_valid = 1'b0;
      step(); step();
      checks++;
      if (obs_vec !== exp_vec()) begin
         failures++;
         $display("FAIL redir_hold_stalled got=%h exp=%h", obs_vec, exp_vec());
      end
      stall_F = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 4 && !seen; k++) begin
         step();
         if (valid_D === 1'b1) begin
            seen = 1'b1;
            checks++;
            if ({instr_D, pc_D} !== {mem[8'h80], 8'h80}) begin
               failures++;
               $display("FAIL redir_hold first valid got i=%h pc=%h want %h/80",
                        instr_D, pc_D, mem[8'h80]);
            end
         end
      end
      if (!seen) begin
         failures++;
         checks++;
         $display("FAIL redir_hold timeout no valid instr_D, want pc 80");
      end
   endtask

   task automatic test_wrap();
      logic [3:0] epc;
      do_reset();
      for (int k = 0; k < 20; k++) begin
         step();
         checks++;
         if ($isunknown(imem_addr4)) begin
            failures++;
            $display("FAIL wrap_addr k=%0d imem_addr=%h want known", k, imem_addr4);
         end
         if (k >= 1) begin
            epc = 4'((k - 1) % 16);
            checks++;
            if ({valid_D4, pc_D4, instr_D4} !== {1'b1, epc, mem4[epc]}) begin
               failures++;
               $display("FAIL wrap k=%0d got v=%b pc=%h i=%h want 1/%h/%h",
                        k, valid_D4, pc_D4, instr_D4, epc, mem4[epc]);
            end
         end
      end
   endtask

   task automatic test_reset_hold();
      do_reset();
      step(); step(); step();
      stall_F = 1'b1;
      step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if ({valid_D, instr_D, pc_D, imem_addr} !== {1'b0, 16'h0, 8'h0, 8'h00}) begin
         failures++;
         $display("FAIL reset_hold got v=%b i=%h pc=%h a=%h want 0/0000/00/00",
                  valid_D, instr_D, pc_D, imem_addr);
      end
      stall_F = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (obs_vec !== exp_vec()) begin
            failures++;
            $display("FAIL reset_hold_after k=%0d got=%h exp=%h", k, obs_vec, exp_vec());
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      do_reset();
      for (int k = 0; k < 500; k++) begin
         rst            = ($urandom_range(0, 99) < 1);
         stall_F        = ($urandom_range(0, 99) < 30);
         flush_F        = ($urandom_range(0, 99) < 10);
         redirect_valid = ($urandom_range(0, 99) < 8);
         redirect_pc    = 8'($urandom);
         if (redirect_valid && $urandom_range(0, 1) == 1) flush_F = 1'b1;
         step();
         checks++;
         if (obs_vec !== exp_vec()) begin
            failures++;
            $display("FAIL random k=%0d r=%b s=%b f=%b rv=%b got=%h exp=%h",
                     k, rst, stall_F, flush_F, redirect_valid, obs_vec, exp_vec());
         end
      end
      rst = 1'b0; stall_F = 1'b0; flush_F = 1'b0; redirect_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
      for (int i = 0; i < 16; i++)  mem4[i] = 16'h2000 + 16'(i * 3);
      m_pc_f = 8'h0; m_inf_pc = 8'h0; m_pc_d = 8'h0;
      m_inf_v = 1'b0; m_valid = 1'b0; m_instr = 16'h0;
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_redirect_hold();
      test_wrap();
      test_reset_hold();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
